hdc_class_memory_engine: RTL and testbench
==========================================

# hdc_class_memory_engine

Parametrised class-hypervector memory for the sparse one-shot HDC datapath: accumulates encoded query hypervectors into per-class saturating counters, binarises them, and runs overlap-based associative search with argmax. It sits between the feature-mapping encoder and the top-level controller. It generalises the fixed 26-class, train-then-test flow to any class count and dimension, and adds chunked processing, a valid/ready command handshake, memory clear, error reporting and mispredict-driven retraining.

## Interface
- DIM, 1024: hypervector dimension in bits; must be a multiple of CHUNK.
- CHUNK, 64: hypervector bits processed per cycle; NCHUNK = DIM/CHUNK.
- CLASS_COUNT, 26: number of classes (at least 2).
- CNT_W, 8: width of the per-bit accumulator counter and the per-class sample counter.
- CLASS_W, $clog2(CLASS_COUNT): derived class index width.
- SCORE_W, $clog2(DIM+1): derived overlap score width.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global advance enable; when low, all state holds.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when state is IDLE and en=1.
- cmd_op  in  3  TRAIN=0, BINARIZE=1, INFER=2, RETRAIN=3, CLEAR=4; other codes behave as no-op with err.
- cmd_label  in  CLASS_W  class label for TRAIN, RETRAIN, and scored INFER.
- cmd_label_valid  in  1  INFER only: compare the result against cmd_label.
- query_hv  in  DIM  encoded query; captured on accept.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse with done on a bad label or bad op.
- result_valid  out  1  one-cycle pulse with done for INFER and RETRAIN.
- class_inference  out  CLASS_W  winning class; held until the next result.
- best_score  out  SCORE_W  overlap of the winning class; held.
- infer_count  out  16  number of scored inferences, saturating.
- correct_count  out  16  number of correct scored inferences, saturating.

## Operation
- **States:** IDLE, ACC, BIN, SCORE, ARGMAX, ADAPT, CLR, DONE. A chunk index counts 0..NCHUNK-1 in ACC, BIN, SCORE, ADAPT and CLR.
- **Accept:** on cmd_valid & cmd_ready, latch the op, label, label_valid and query_hv, then leave IDLE.
- **TRAIN (ACC):**
  - For each set bit of the captured query in the current chunk, increment counter[label][bit], saturating at 2^CNT_W-1.
  - After the last chunk, increment sample_cnt[label], saturating.
- **BINARIZE (BIN):** for every class in parallel, per chunk: bin[c][bit] = (counter[c][bit] > sample_cnt[c]>>1).
- **INFER:**
  - SCORE: score[c] += popcount(query_chunk & bin[c]_chunk) for all classes in parallel.
  - ARGMAX: compare scores sequentially, one class per cycle from 0 to CLASS_COUNT-1. The winner changes only on a strictly greater score, so ties resolve to the lowest index.
  - If label_valid, increment infer_count, and increment correct_count on a match.
- **RETRAIN:**
  - Run as INFER, scored against cmd_label.
  - On a mispredict, enter ADAPT. Per chunk, for each set query bit: counter[label] +1 (saturating) and counter[pred] -1 (floor 0). sample_cnt is unchanged.
  - On a correct prediction, skip ADAPT.
- **CLEAR (CLR):** zero all counters, sample_cnt and bin, one chunk per cycle across all classes. infer_count and correct_count are also zeroed.
- **Errors:**
  - cmd_label ≥ CLASS_COUNT on TRAIN or RETRAIN: go straight to DONE with err, no memory change.
  - cmd_label ≥ CLASS_COUNT on scored INFER: the inference still runs, the comparison is skipped, and err is pulsed.
- **Reset:** all state returns to IDLE, and all memories and counters are zeroed. cmd_ready=1 (when en=1); done, err and result_valid are 0; class_inference, best_score, infer_count and correct_count are 0.

## Timing
- Cycle 0 is the accept edge. done is high exactly in cycle N:
  - TRAIN, BINARIZE, CLEAR: N = NCHUNK+1.
  - INFER, or RETRAIN that predicts correctly: N = NCHUNK+CLASS_COUNT+1.
  - RETRAIN with a mispredict: N = 2·NCHUNK+CLASS_COUNT+1.
  - Error or bad op: N = 1.
- cmd_ready is low from cycle 1 to cycle N, and returns high in cycle N+1 (if en=1).
- Results and counters update at the edge that raises done.
- en=0 freezes every register, including the pulses. Latencies stretch by the number of en-low cycles.
- A rst asserted mid-command aborts it with no done. A memory partially updated by that command is still cleared by reset.
- Commands issued while busy are not accepted; cmd_valid must be held until accept.

## Structure
- Package hdc_mem_pkg holds the op enum, the state enum, and the saturating-add/subtract functions.
- Sub-module hdc_chunk_popcount (CHUNK-bit popcount) is instantiated CLASS_COUNT times.
- The counter array and the bin array are register arrays indexed [class][bit].

## Test plan
Bench configuration: DIM=256, CHUNK=64, CLASS_COUNT=4, CNT_W=4, so NCHUNK=4.
- **Reset:** hold rst 2 cycles → cmd_ready=1, done=0, class_inference=0, correct_count=0.
- **Train and infer:**
  - Stimulus: TRAIN label 2 with query bits[63:0]=1, three times; BINARIZE; scored INFER of the same query with label 2.
  - Response: done at cycle 9 after accept, class_inference=2, best_score=64, correct_count=1, infer_count=1.
- **Tie:** INFER on a cleared memory → class_inference=0, best_score=0.
- **Saturation:** 20 TRAINs of label 1 with an all-ones query → counters=15, sample_cnt=15; after BINARIZE, bin[1] is all ones; INFER → best_score=256.
- **Retrain:**
  - Setup: bin[0] covers bits[127:0]; query = bits[127:64]; RETRAIN label 3.
  - Response: prediction 0 mispredicts; done at cycle 13; counter[3][127:64] +1 and counter[0][127:64] -1.
- **Error and stall:**
  - TRAIN label 5 → done and err at cycle 1, memory unchanged.
  - en low for 3 cycles during INFER → done delayed by exactly 3 cycles.

Source files
------------

// File: rtl/hdc_class_memory_engine_pkg.sv
// Shared types and saturating arithmetic for the HDC class-hypervector memory.
package hdc_mem_pkg;

  typedef enum logic [2:0] {
    OP_TRAIN    = 3'd0,
    OP_BINARIZE = 3'd1,
    OP_INFER    = 3'd2,
    OP_RETRAIN  = 3'd3,
    OP_CLEAR    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_BIN, S_SCORE, S_ARGMAX, S_ADAPT, S_CLR, S_DONE
  } state_e;

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  function automatic int sat_dec(input int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/hdc_class_memory_engine_popcount.sv
// CHUNK-bit population count, one instance per class.
module hdc_chunk_popcount #(
  parameter int CHUNK = 64,
  parameter int PC_W  = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [PC_W-1:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) count = count + PC_W'(bits[i]);
  end
endmodule

// File: rtl/hdc_class_memory_engine.sv
// Class-hypervector memory: chunked training, binarisation, overlap search with
// sequential argmax, and mispredict-driven retraining.
module hdc_class_memory_engine
  import hdc_mem_pkg::*;
#(
  parameter int DIM         = 1024,
  parameter int CHUNK       = 64,
  parameter int CLASS_COUNT = 26,
  parameter int CNT_W       = 8,
  parameter int CLASS_W     = $clog2(CLASS_COUNT),
  parameter int SCORE_W     = $clog2(DIM + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [CLASS_W-1:0] cmd_label,
  input  logic               cmd_label_valid,
  input  logic [DIM-1:0]     query_hv,
  output logic               done,
  output logic               err,
  output logic               result_valid,
  output logic [CLASS_W-1:0] class_inference,
  output logic [SCORE_W-1:0] best_score,
  output logic [15:0]        infer_count,
  output logic [15:0]        correct_count
);
  localparam int NCHUNK  = DIM / CHUNK;
  localparam int CH_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W   = $clog2(DIM);
  localparam int PC_W    = $clog2(CHUNK + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  state_e state, nstate;
  logic [2:0]         op_q;
  logic [CLASS_W-1:0] lab_q, aidx, win, win_n, pub_cls;
  logic [DIM-1:0]     hv_q;
  logic               err_q, rv_q, scored_q;
  logic [CH_W-1:0]    chunk;
  logic [SCORE_W-1:0] best, best_n, cur, pub_score;

  logic [CNT_W-1:0] counter [CLASS_COUNT][DIM];
  logic [CNT_W-1:0] sample_cnt [CLASS_COUNT];
  logic [CLASS_COUNT-1:0][DIM-1:0]     bin;
  logic [CLASS_COUNT-1:0][SCORE_W-1:0] score;
  logic [CLASS_COUNT-1:0][PC_W-1:0]    pc;

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] bidx [CHUNK];
  logic [CHUNK-1:0] q_chunk;
  logic last_chunk, last_class, bad_in, take, go_adapt, pub_en;

  assign bad_in     = int'(cmd_label) >= CLASS_COUNT;
  assign last_chunk = (chunk == CH_W'(NCHUNK - 1));
  assign last_class = (aidx == CLASS_W'(CLASS_COUNT - 1));
  assign base       = IDX_W'(chunk) * IDX_W'(CHUNK);
  assign q_chunk    = hv_q[base +: CHUNK];

  always_comb
    for (int j = 0; j < CHUNK; j++) bidx[j] = base + IDX_W'(j);

  for (genvar c = 0; c < CLASS_COUNT; c++) begin : g_pc
    hdc_chunk_popcount #(.CHUNK(CHUNK), .PC_W(PC_W)) u_pc (
      .bits  (q_chunk & bin[c][base +: CHUNK]),
      .count (pc[c])
    );
  end

  // Ties keep the earlier (lower-index) winner; class 0 always seeds the search.
  assign cur      = score[aidx];
  assign take     = (aidx == '0) || (cur > best);
  assign win_n    = take ? aidx : win;
  assign best_n   = take ? cur : best;
  assign go_adapt = (op_q == OP_RETRAIN) && (win_n != lab_q);

  assign pub_en    = (state == S_ARGMAX && last_class && !go_adapt) ||
                     (state == S_ADAPT && last_chunk);
  assign pub_cls   = (state == S_ARGMAX) ? win_n : win;
  assign pub_score = (state == S_ARGMAX) ? best_n : best;

  always_ff @(posedge clk)
    if (rst)     state <= S_IDLE;
    else if (en) state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_TRAIN:    nstate = bad_in ? S_DONE : S_ACC;
          OP_BINARIZE: nstate = S_BIN;
          OP_INFER:    nstate = S_SCORE;
          OP_RETRAIN:  nstate = bad_in ? S_DONE : S_SCORE;
          OP_CLEAR:    nstate = S_CLR;
          default:     nstate = S_DONE;
        endcase
      end
      S_ACC, S_BIN, S_CLR, S_ADAPT: if (last_chunk) nstate = S_DONE;
      S_SCORE:  if (last_chunk) nstate = S_ARGMAX;
      S_ARGMAX: if (last_class) nstate = go_adapt ? S_ADAPT : S_DONE;
      S_DONE:   nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state == S_IDLE) && en;
    done         = (state == S_DONE);
    err          = done && err_q;
    result_valid = done && rv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; lab_q <= '0; hv_q <= '0;
      err_q <= 1'b0; rv_q <= 1'b0; scored_q <= 1'b0;
      chunk <= '0; aidx <= '0; win <= '0; best <= '0; score <= '0;
      class_inference <= '0; best_score <= '0;
      infer_count <= '0; correct_count <= '0;
    end else if (en) begin
      if (state == S_IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        lab_q    <= cmd_label;
        hv_q     <= query_hv;
        err_q    <= (cmd_op > 3'd4) || (bad_in && (cmd_op == OP_TRAIN || cmd_op == OP_RETRAIN ||
                    (cmd_op == OP_INFER && cmd_label_valid)));
        rv_q     <= (cmd_op == OP_INFER) || (cmd_op == OP_RETRAIN && !bad_in);
        scored_q <= !bad_in && ((cmd_op == OP_INFER && cmd_label_valid) || cmd_op == OP_RETRAIN);
        chunk    <= '0;
        aidx     <= '0;
        score    <= '0;
      end
      if (state inside {S_ACC, S_BIN, S_SCORE, S_ADAPT, S_CLR})
        chunk <= last_chunk ? '0 : chunk + CH_W'(1);
      if (state == S_SCORE)
        for (int c = 0; c < CLASS_COUNT; c++) score[c] <= score[c] + SCORE_W'(pc[c]);
      if (state == S_ARGMAX) begin
        aidx <= aidx + CLASS_W'(1);
        win  <= win_n;
        best <= best_n;
      end
      if (pub_en) begin
        class_inference <= pub_cls;
        best_score      <= pub_score;
        if (scored_q) begin
          infer_count <= 16'(sat_inc(int'(infer_count), 65535));
          if (pub_cls == lab_q) correct_count <= 16'(sat_inc(int'(correct_count), 65535));
        end
      end
      if (state == S_CLR && last_chunk) begin
        infer_count   <= '0;
        correct_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CLASS_COUNT; c++) begin
        sample_cnt[c] <= '0;
        for (int b = 0; b < DIM; b++) counter[c][b] <= '0;
      end
      bin <= '0;
    end else if (en) begin
      case (state)
        S_ACC: begin
          for (int j = 0; j < CHUNK; j++)
            if (hv_q[bidx[j]])
              counter[lab_q][bidx[j]] <= CNT_W'(sat_inc(int'(counter[lab_q][bidx[j]]), CNT_MAX));
          if (last_chunk)
            sample_cnt[lab_q] <= CNT_W'(sat_inc(int'(sample_cnt[lab_q]), CNT_MAX));
        end
        S_BIN:
          for (int c = 0; c < CLASS_COUNT; c++)
            for (int j = 0; j < CHUNK; j++)
              bin[c][bidx[j]] <= counter[c][bidx[j]] > (sample_cnt[c] >> 1);
        // Mispredict only: label and predicted class always differ here.
        S_ADAPT:
          for (int j = 0; j < CHUNK; j++)
            if (hv_q[bidx[j]]) begin
              counter[lab_q][bidx[j]] <= CNT_W'(sat_inc(int'(counter[lab_q][bidx[j]]), CNT_MAX));
              counter[win][bidx[j]]   <= CNT_W'(sat_dec(int'(counter[win][bidx[j]])));
            end
        S_CLR: begin
          for (int c = 0; c < CLASS_COUNT; c++) begin
            for (int j = 0; j < CHUNK; j++) begin
              counter[c][bidx[j]] <= '0;
              bin[c][bidx[j]]     <= 1'b0;
            end
            if (last_chunk) sample_cnt[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_class_memory_engine.sv
// Directed table-driven bench: DIM=256, CHUNK=64, four classes, 4-bit counters,
// plus a five-class instance so that an out-of-range label is expressible.
module tb_hdc_class_memory_engine;
  localparam logic [255:0] ZERO = '0;
  localparam logic [255:0] ALL  = {256{1'b1}};
  localparam logic [255:0] L64  = {192'b0, {64{1'b1}}};
  localparam logic [255:0] L128 = {128'b0, {128{1'b1}}};
  localparam logic [255:0] M64  = {128'b0, {64{1'b1}}, 64'b0};

  logic clk = 1'b0;
  logic rst, en, cmd_valid, cmd_valid2, cmd_label_valid;
  logic [2:0] cmd_op, cmd_label2;
  logic [1:0] cmd_label;
  logic [255:0] query_hv;
  logic cmd_ready, done, err, result_valid;
  logic cmd_ready2, done2, err2, result_valid2;
  logic [1:0] class_inference;
  logic [2:0] class_inference2;
  logic [8:0] best_score, best_score2;
  logic [15:0] infer_count, correct_count, infer_count2, correct_count2;

  always #5 clk = ~clk;

  hdc_class_memory_engine #(.DIM(256), .CHUNK(64), .CLASS_COUNT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_label(cmd_label), .cmd_label_valid(cmd_label_valid),
    .query_hv(query_hv), .done(done), .err(err), .result_valid(result_valid),
    .class_inference(class_inference), .best_score(best_score),
    .infer_count(infer_count), .correct_count(correct_count));

  hdc_class_memory_engine #(.DIM(256), .CHUNK(64), .CLASS_COUNT(5), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_label(cmd_label2), .cmd_label_valid(cmd_label_valid),
    .query_hv(query_hv), .done(done2), .err(err2), .result_valid(result_valid2),
    .class_inference(class_inference2), .best_score(best_score2),
    .infer_count(infer_count2), .correct_count(correct_count2));

  bit sel;
  logic m_ready, m_done, m_err, m_rv;
  logic [2:0] m_cls;
  logic [8:0] m_score;
  logic [15:0] m_ic, m_cc;

  always_comb begin
    if (sel) begin
      m_ready = cmd_ready2; m_done = done2; m_err = err2; m_rv = result_valid2;
      m_cls = class_inference2; m_score = best_score2; m_ic = infer_count2; m_cc = correct_count2;
    end else begin
      m_ready = cmd_ready; m_done = done; m_err = err; m_rv = result_valid;
      m_cls = {1'b0, class_inference}; m_score = best_score; m_ic = infer_count; m_cc = correct_count;
    end
  end

  typedef struct {
    bit sel; logic [2:0] op; logic [2:0] lbl; bit lv; logic [255:0] hv;
    int rep; int stall; int lat; bit err; bit rv; bit chk;
    logic [2:0] cls; logic [8:0] sc; int ic; int cc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic vec_t mk(bit s, logic [2:0] op, logic [2:0] lbl, bit lv, logic [255:0] hv,
                              int rep, int stall, int lat, bit e, bit rv, bit chk,
                              logic [2:0] cls, logic [8:0] sc, int ic, int cc);
    vec_t v;
    v.sel = s; v.op = op; v.lbl = lbl; v.lv = lv; v.hv = hv; v.rep = rep; v.stall = stall;
    v.lat = lat; v.err = e; v.rv = rv; v.chk = chk; v.cls = cls; v.sc = sc; v.ic = ic; v.cc = cc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx, input bit last);
    int lat;
    bit got;
    sel = v.sel;
    @(negedge clk);
    cmd_op = v.op; cmd_label = v.lbl[1:0]; cmd_label2 = v.lbl;
    cmd_label_valid = v.lv; query_hv = v.hv;
    if (v.sel) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !m_ready; k++) @(negedge clk);
    if (!m_ready) check($sformatf("v%0d ready_timeout", idx), 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      lat = k;
      if (v.stall != 0 && k == v.stall) en = 1'b0;
      if (v.stall != 0 && k == v.stall + 3) en = 1'b1;
      if (m_done) got = 1'b1;
    end
    if (!got) lat = -1;
    if (last) begin
      check($sformatf("v%0d latency", idx), lat, v.lat);
      check($sformatf("v%0d err", idx), m_err, v.err);
      check($sformatf("v%0d result_valid", idx), m_rv, v.rv);
      check($sformatf("v%0d infer_count", idx), m_ic, v.ic);
      check($sformatf("v%0d correct_count", idx), m_cc, v.cc);
      if (v.chk) begin
        check($sformatf("v%0d class_inference", idx), m_cls, v.cls);
        check($sformatf("v%0d best_score", idx), m_score, v.sc);
      end
      @(negedge clk);
      check($sformatf("v%0d ready_after", idx), {m_ready, m_done}, 2'b10);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_label_valid = 1'b0;
    cmd_op = '0; cmd_label = '0; cmd_label2 = '0; query_hv = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset done", done, 0);
    check("reset class_inference", class_inference, 0);
    check("reset correct_count", correct_count, 0);
    check("reset best_score", best_score, 0);
    check("reset infer_count", infer_count, 0);
    rst = 1'b0;

    //                sel op lbl lv hv   rep stall lat err rv chk cls sc  ic cc
    tbl.push_back(mk(0, 4, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0)); // clear
    tbl.push_back(mk(0, 2, 0, 0, ALL,  1, 0,  9, 0, 1, 1, 0, 0,   0, 0)); // tie on empty memory
    tbl.push_back(mk(0, 0, 2, 0, L64,  3, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 1, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 2, 2, 1, L64,  1, 0,  9, 0, 1, 1, 2, 64,  1, 1));
    tbl.push_back(mk(0, 2, 1, 1, L64,  1, 0,  9, 0, 1, 1, 2, 64,  2, 1)); // scored miss
    tbl.push_back(mk(0, 5, 0, 0, ZERO, 1, 0,  1, 1, 0, 0, 0, 0,   2, 1)); // bad op
    tbl.push_back(mk(0, 2, 2, 1, L64,  1, 2, 12, 0, 1, 1, 2, 64,  3, 2)); // 3-cycle en stall
    tbl.push_back(mk(0, 4, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 1, 0, ALL, 20, 0,  5, 0, 0, 0, 0, 0,   0, 0)); // saturate
    tbl.push_back(mk(0, 1, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 2, 0, 0, ALL,  1, 0,  9, 0, 1, 1, 1, 256, 0, 0));
    tbl.push_back(mk(0, 4, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0, L128, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 1, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 3, 3, 0, M64,  1, 0, 13, 0, 1, 1, 0, 64,  1, 0)); // retrain mispredict
    tbl.push_back(mk(0, 1, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   1, 0));
    tbl.push_back(mk(0, 2, 0, 0, M64,  1, 0,  9, 0, 1, 1, 3, 64,  1, 0)); // class 3 gained 127:64
    tbl.push_back(mk(0, 2, 0, 0, L128, 1, 0,  9, 0, 1, 1, 0, 64,  1, 0)); // class 0 lost 127:64, tie
    tbl.push_back(mk(0, 3, 3, 0, M64,  1, 0,  9, 0, 1, 1, 3, 64,  2, 1)); // retrain correct
    tbl.push_back(mk(1, 0, 5, 0, ALL,  1, 0,  1, 1, 0, 0, 0, 0,   0, 0)); // bad train label
    tbl.push_back(mk(1, 1, 0, 0, ZERO, 1, 0,  5, 0, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, 2, 6, 1, ALL,  1, 0, 10, 1, 1, 1, 0, 0,   0, 0)); // bad scored infer label

    foreach (tbl[i])
      for (int r = 0; r < tbl[i].rep; r++) run(tbl[i], i, r == tbl[i].rep - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
